bit_serial_adder: RTL

//   Sequential adder that computes sum = a + b + carryIn one bit per clock, LSB first.
//   It uses a single full-adder cell with a registered carry fed back each cycle.
//   It is the area-minimal alternative to the ripple-carry adder, and its outputs have the same meaning.

---
 rtl/bit_serial_adder_if.sv | 24 ++
 rtl/bit_serial_adder.sv | 90 +++++++++
 2 files changed

// File: rtl/bit_serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master drives the request and operands; the slave returns status and the result.
interface bit_serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryOut;

    modport master (
        output start, a, b, carryIn,
        input  busy, done, sum, carryOut
    );

    modport slave (
        input  start, a, b, carryIn,
        output busy, done, sum, carryOut
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell with a registered carry computes
// sum = a + b + carryIn one bit per clock, LSB first, under a start/busy/done handshake.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    bit_serial_adder_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] acc_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Next sum bit and carry from the shared full-adder cell.
    logic             s_d;
    logic             c_d;
    logic [WIDTH-1:0] acc_d;

    // Full-adder cell on the current LSBs and the fed-back carry.
    always_comb begin
        s_d   = opa_q[0] ^ opb_q[0] ^ cy_q;
        c_d   = (opa_q[0] & opb_q[0]) | (opa_q[0] & cy_q) | (opb_q[0] & cy_q);
        acc_d = {s_d, acc_q[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; result registers only change on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        cy_q    <= bus.carryIn;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    opa_q <= {1'b0, opa_q[WIDTH-1:1]};
                    opb_q <= {1'b0, opb_q[WIDTH-1:1]};
                    cy_q  <= c_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= acc_d;
                        cout_q  <= c_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.sum      = sum_q;
    assign bus.carryOut = cout_q;

endmodule
